// File: rtl/instr_fetch.sv
// Instruction fetch initiator: sequential PC generation, redirects, and a
// 1-entry hold register behind a valid/ready handshake to decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch #(
  parameter int unsigned               ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]     BOOT_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  instr_en_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [31:0]           instr_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic [31:0]           fetch_cnt_o,
  output logic [31:0]           stall_cnt_o
);

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = {BOOT_ADDR[ADDR_WIDTH-1:2], 2'b00};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [31:0]           hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;

  logic                  transfer;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^redirect_addr_i[1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = 1'b0;
    req_pc_d     = req_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    // A redirect kills whatever would have been presented this cycle.
    instr_valid_o = ~redirect_i & (hold_valid_q | req_q);
    transfer      = instr_valid_o & instr_ready_i;
    instr_en_o    = (state_q == RUN) & (redirect_i | ~instr_valid_o | instr_ready_i);
    instr_addr_o  = redirect_i ? {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00} : pc_q;

    // Outside an active response the raw memory bus is masked to keep instr_o quiet.
    instr_o    = hold_valid_q ? hold_instr_q : (req_q ? instr_rdata_i : 32'd0);
    instr_pc_o = hold_valid_q ? hold_pc_q : req_pc_q;

    if (instr_en_o) begin
      req_d    = 1'b1;
      req_pc_d = instr_addr_o;
      pc_d     = instr_addr_o + ADDR_WIDTH'(4);
    end

    if (redirect_i) begin
      hold_valid_d = 1'b0;
    end else if (transfer) begin
      hold_valid_d = 1'b0;
    end else if (req_q && !instr_ready_i && !hold_valid_q) begin
      // Memory data is only valid this cycle, so park it until decode accepts.
      hold_valid_d = 1'b1;
      hold_instr_d = instr_rdata_i;
      hold_pc_d    = req_pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the hold data register is reset too, so instr_o is defined out of reset.
      state_q      <= BOOT;
      pc_q         <= BOOT_PC;
      req_q        <= 1'b0;
      req_pc_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      req_pc_q     <= req_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (transfer) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (instr_valid_o && !instr_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table plus a
// transfer scoreboard fed by a simple 1-cycle-latency memory model.
module tb_instr_fetch;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        instr_en;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] raddr;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch #(
    .ADDR_WIDTH (32),
    .BOOT_ADDR  (BOOT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .instr_en_o      (instr_en),
    .instr_addr_o    (instr_addr),
    .instr_rdata_i   (instr_rdata),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .fetch_cnt_o     (fetch_cnt),
    .stall_cnt_o     (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory returns data only for the cycle after a request; otherwise garbage.
  always @(posedge clk) begin
    instr_rdata <= instr_en ? mem_word(instr_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic redir, input logic [31:0] raddr,
                     input logic en, input logic [31:0] addr, input logic vld,
                     input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.raddr = raddr;
    v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
    vecs.push_back(v);
  endtask

  // Scoreboard: every transfer must match the next expected PC and its word.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected transfer: got pc %h expected none", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("xfer pc", instr_pc, e);
        check("xfer instr", instr, mem_word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;

    //  rdy   redir raddr          en    addr           vld   pc
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);
    add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_010C, 1'b1, 32'h0000_0108);
    add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0110, 1'b1, 32'h0000_010C);
    add(1'b0, 1'b1, 32'h0000_0203, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);
    add(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    add(1'b1, 1'b1, 32'h0000_0120, 1'b1, 32'h0000_0120, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0124, 1'b1, 32'h0000_0120);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0128, 1'b1, 32'h0000_0124);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_012C, 1'b1, 32'h0000_0128);
    add(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0130, 1'b1, 32'h0000_012C);

    repeat (2) @(posedge clk);
    #1;
    check("reset en", {31'd0, instr_en}, 32'd0);
    check("reset addr", instr_addr, BOOT);
    check("reset valid", {31'd0, instr_valid}, 32'd0);
    check("reset instr", instr, 32'd0);
    check("reset pc", instr_pc, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot en", {31'd0, instr_en}, 32'd0);
    check("boot valid", {31'd0, instr_valid}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      instr_ready   = vecs[i].rdy;
      redirect      = vecs[i].redir;
      redirect_addr = vecs[i].raddr;
      if (vecs[i].rdy && vecs[i].vld) exp_q.push_back(vecs[i].pc);
      #3;
      check($sformatf("row%0d en", i), {31'd0, instr_en}, {31'd0, vecs[i].en});
      check($sformatf("row%0d addr", i), instr_addr, vecs[i].addr);
      check($sformatf("row%0d valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].vld});
      if (vecs[i].vld) begin
        check($sformatf("row%0d pc", i), instr_pc, vecs[i].pc);
        check($sformatf("row%0d instr", i), instr, mem_word(vecs[i].pc));
      end
    end

    // Counters, then an asynchronous reset while 0x130 is being presented.
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd10);
    check("stall_cnt", stall_cnt, 32'd4);
`else
    check("fetch_cnt", fetch_cnt, 32'd0);
    check("stall_cnt", stall_cnt, 32'd0);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst en", {31'd0, instr_en}, 32'd0);
    check("midrst addr", instr_addr, BOOT);
    check("midrst valid", {31'd0, instr_valid}, 32'd0);
    check("midrst instr", instr, 32'd0);
    check("midrst pc", instr_pc, 32'd0);
    check("midrst fetch_cnt", fetch_cnt, 32'd0);
    check("midrst stall_cnt", stall_cnt, 32'd0);

    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reboot en", {31'd0, instr_en}, 32'd0);

    @(posedge clk);
    #1;
    check("restart en", {31'd0, instr_en}, 32'd1);
    check("restart addr", instr_addr, BOOT);
    check("restart valid", {31'd0, instr_valid}, 32'd0);

    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(BOOT + 32'(4 * k));
      #3;
      check("restart pc", instr_pc, BOOT + 32'(4 * k));
      check("restart next addr", instr_addr, BOOT + 32'(4 * (k + 1)));
    end

    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
